// File: rtl/seg_pkg.sv
// Shared segment types and constants for the 7-segment encode/drive path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package seg_pkg;

  localparam int SEG_W = 7;

  // bit6 = seg a ... bit0 = seg g, active-high
  typedef logic [SEG_W-1:0] seg_t;

  localparam seg_t SEG_BLANK = 7'b0000000;

endpackage

// File: rtl/seg_scan_prescaler.sv
// Slot timer for the digit scan: cycle counter, digit index and end-of-scan wrap strobe.
// Latency: wrap is combinational from the registered counter and index.
// Backpressure: none, free-running.
module seg_scan_prescaler #(
  parameter int REFRESH_DIV = 50000,
  parameter int NUM_DIGITS  = 4,
  parameter int CNT_W       = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1,
  parameter int IDX_W       = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic             clk,
  input  logic             rst,
  output logic [CNT_W-1:0] cnt,
  output logic [IDX_W-1:0] idx,
  output logic             wrap
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(NUM_DIGITS - 1);

  logic tick;

  assign tick = (cnt == CNT_MAX);
  assign wrap = tick && (idx == IDX_MAX);

  // Count cycles within a slot; step to the next digit at the end of each slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      idx <= '0;
    end else if (tick) begin
      cnt <= '0;
      idx <= (idx == IDX_MAX) ? '0 : idx + IDX_W'(1);
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/seg_scan_driver.sv
// Multiplexed common-anode 7-seg driver with double-buffered frames swapped at scan wrap (SEG_DIM_EN adds PWM dimming).
// Latency: seg_out/an_n are registered, one cycle behind the scan counter; a frame shows from the first wrap after accept.
// Backpressure: frame_ready drops the cycle after an accept and returns the cycle after the pending frame is swapped in.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int BLANK_CYC   = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        frame_valid,
  output logic                        frame_ready,
  input  logic [SEG_W*NUM_DIGITS-1:0] frame_data,
  output seg_t                        seg_out,
  output logic [NUM_DIGITS-1:0]       an_n
`ifdef SEG_DIM_EN
  ,
  input  logic [3:0]                  duty
`endif
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CNT_W-1:0] BLANK_V = CNT_W'(BLANK_CYC);

  logic [CNT_W-1:0] cnt;
  logic [IDX_W-1:0] idx;
  logic             wrap;

  seg_t pending [NUM_DIGITS];
  seg_t active  [NUM_DIGITS];
  logic pending_full;
  logic pending_full_nxt;
  logic accept;
  logic swap;

  logic                  blank;
  logic                  lit;
  seg_t                  seg_nxt;
  logic [NUM_DIGITS-1:0] an_nxt;

  seg_scan_prescaler #(
    .REFRESH_DIV (REFRESH_DIV),
    .NUM_DIGITS  (NUM_DIGITS),
    .CNT_W       (CNT_W),
    .IDX_W       (IDX_W)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .cnt  (cnt),
    .idx  (idx),
    .wrap (wrap)
  );

  // frame_ready mirrors pending-empty, so an accept can never coincide with a swap.
  assign accept = frame_valid && frame_ready;
  assign swap   = wrap && pending_full;

  // Pending occupancy after this edge: filled by accept, drained by swap.
  always_comb begin
    pending_full_nxt = pending_full;
    if (swap) begin
      pending_full_nxt = 1'b0;
    end
    if (accept) begin
      pending_full_nxt = 1'b1;
    end
  end

  // Frame buffers and handshake; active only changes at scan wrap so frames never tear.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_full <= 1'b0;
      frame_ready  <= 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        pending[i] <= SEG_BLANK;
        active[i]  <= SEG_BLANK;
      end
    end else begin
      pending_full <= pending_full_nxt;
      frame_ready  <= !pending_full_nxt;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (swap) begin
          active[i] <= pending[i];
        end
        if (accept) begin
          pending[i] <= frame_data[SEG_W*i +: SEG_W];
        end
      end
    end
  end

`ifdef SEG_DIM_EN
  logic [3:0] pwm_cnt;

  // Free-running PWM phase; the anode is gated off once the phase reaches duty.
  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_cnt <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + 4'd1;
    end
  end

  assign lit = !blank && (pwm_cnt < duty);
`else
  assign lit = !blank;
`endif

  assign blank = (cnt < BLANK_V);

  // Next output pattern: blank window at slot start, else the selected digit of the active frame.
  always_comb begin
    seg_nxt = SEG_BLANK;
    an_nxt  = '1;
    if (!blank) begin
      seg_nxt = active[idx];
    end
    if (lit) begin
      an_nxt[idx] = 1'b0;
    end
  end

  // Register the pins so they change cleanly on the clock edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      seg_out <= SEG_BLANK;
      an_n    <= '1;
    end else begin
      seg_out <= seg_nxt;
      an_n    <= an_nxt;
    end
  end

endmodule
